keypad_scanner: RTL

- Input-side counterpart to the multiplexed 7-segment display path. The display block scans digit enables outward; this block scans a 4x4 matrix keypad (Pmod KYPD) inward.
- It drives one column low at a time, samples the rows, debounces, and reports key events.
- It also assembles a 32-bit hex-entry value that the processor top level consumes alongside x/y.
- It runs on the undivided board clock.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_frame_eval.sv | 29 ++
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } kp_state_e;

    // One evaluated scan frame: a single clean key, or nothing usable.
    typedef struct packed {
        logic       is_key;
        logic [3:0] code;
    } frame_result_t;

    // Nibble n holds the code at {row, col} = n.
    // Rows: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D.
    localparam logic [63:0] CODE_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] code_lookup(input logic [3:0] rc);
        return CODE_MAP[{rc, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_frame_eval.sv
// Reduces one full 16-bit scan frame (bit = col*4 + row) to a single key code or NONE.
module keypad_frame_eval
    import keypad_pkg::*;
(
    input  logic [15:0] frame_i,
    output logic [4:0]  result_o
);

    logic [4:0]    hit_cnt;
    logic [3:0]    hit_idx;
    frame_result_t result;

    // More than one closed switch is treated as no key, which also rejects ghosting.
    always_comb begin
        hit_cnt = '0;
        hit_idx = '0;
        for (int b = 0; b < 16; b++) begin
            if (frame_i[b]) begin
                hit_cnt = hit_cnt + 5'd1;
                hit_idx = 4'(b);
            end
        end
        result.is_key = (hit_cnt == 5'd1);
        result.code   = result.is_key ? code_lookup({hit_idx[1:0], hit_idx[3:2]}) : 4'h0;
    end

    assign result_o = result;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, frame debounce and hex-entry register.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 5000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_n,
    input  logic        clr,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] value_out
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [STB_W-1:0] DB_LAST      = STB_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [STB_W-1:0] STABLE_ONE   = STB_W'(1);
    localparam bit               SINGLE_FRAME = (DEBOUNCE_FRAMES == 1);

    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [15:0]      frame_q, frame_d;
    logic             frame_done_q, frame_done_d;
    logic             settle_tc;

    kp_state_e        state_q;
    logic [3:0]       cand_q;
    logic [STB_W-1:0] stable_q;

    logic [4:0]       eval_raw;
    frame_result_t    eval_res;
    logic             new_key;
    logic             press_now;
    logic             release_now;

    for (genvar gi = 0; gi < 4; gi++) begin : g_col_drive
        assign col_n[gi] = (col_idx_q != 2'(gi));
    end

    // Rows seen through the synchronizer are captured only at the end of each settle window.
    always_comb begin
        settle_tc    = (settle_cnt_q == SETTLE_LAST);
        settle_cnt_d = settle_tc ? '0 : settle_cnt_q + 1'b1;
        col_idx_d    = settle_tc ? col_idx_q + 2'd1 : col_idx_q;
        frame_d      = frame_q;
        if (settle_tc) begin
            frame_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        end
        frame_done_d = settle_tc && (col_idx_q == 2'd3);
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            row_meta_q   <= 4'hF;
            row_sync_q   <= 4'hF;
            settle_cnt_q <= '0;
            col_idx_q    <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_meta_q   <= row_in;
            row_sync_q   <= row_meta_q;
            settle_cnt_q <= settle_cnt_d;
            col_idx_q    <= col_idx_d;
            frame_q      <= frame_d;
            frame_done_q <= frame_done_d;
        end
    end

    keypad_frame_eval u_frame_eval (
        .frame_i  (frame_q),
        .result_o (eval_raw)
    );

    assign eval_res = frame_result_t'(eval_raw);

    // A "new" key is one that restarts press debouncing from a count of one.
    always_comb begin
        new_key = 1'b0;
        if (eval_res.is_key) begin
            unique case (state_q)
                IDLE:       new_key = 1'b1;
                PRESS_DB:   new_key = (eval_res.code != cand_q);
                HELD:       new_key = (eval_res.code != key_code);
                RELEASE_DB: new_key = (eval_res.code != key_code);
            endcase
        end
        press_now   = frame_done_q &&
                      ((new_key && SINGLE_FRAME) ||
                       (state_q == PRESS_DB && eval_res.is_key &&
                        eval_res.code == cand_q && stable_q >= DB_LAST));
        release_now = frame_done_q && !eval_res.is_key &&
                      ((state_q == HELD && SINGLE_FRAME) ||
                       (state_q == RELEASE_DB && stable_q >= DB_LAST));
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            stable_q  <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            value_out <= '0;
        end else begin
            key_valid <= press_now;
            if (press_now) begin
                state_q   <= HELD;
                cand_q    <= eval_res.code;
                key_code  <= eval_res.code;
                key_held  <= 1'b1;
                value_out <= clr ? {28'h0, eval_res.code} : {value_out[27:0], eval_res.code};
            end else begin
                if (clr) begin
                    value_out <= '0;
                end
                if (release_now) begin
                    state_q  <= IDLE;
                    key_held <= 1'b0;
                end else if (frame_done_q) begin
                    if (new_key) begin
                        state_q  <= PRESS_DB;
                        cand_q   <= eval_res.code;
                        stable_q <= STABLE_ONE;
                        key_held <= 1'b0;
                    end else begin
                        unique case (state_q)
                            IDLE: begin
                            end
                            PRESS_DB: begin
                                if (eval_res.is_key) begin
                                    stable_q <= stable_q + STABLE_ONE;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end
                            HELD: begin
                                if (!eval_res.is_key) begin
                                    state_q  <= RELEASE_DB;
                                    stable_q <= STABLE_ONE;
                                end
                            end
                            RELEASE_DB: begin
                                if (eval_res.is_key) begin
                                    state_q <= HELD;
                                end else begin
                                    stable_q <= stable_q + STABLE_ONE;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule
